// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU datapath blocks: machine word, collector FSM states
// and small pointer helpers used by the circular lane buffers.
package hs_npu_pkg;

  localparam int unsigned UWORD_W = 32;

  typedef logic [UWORD_W-1:0] uword;

  typedef enum logic {
    COLLECT_IDLE,
    COLLECT_RUN
  } collect_state_e;

  // Pointer width for a buffer of the given depth; at least one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width; must be able to hold the value 'depth' itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hs_npu_collector_lane.sv
// One lane of the output collector: a circular buffer that accepts a push every
// cycle it can, pops on request, and flags words it had to drop.
module hs_npu_collector_lane
  import hs_npu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANE_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  localparam int unsigned PTR_W = ptr_width(LANE_DEPTH);
  localparam int unsigned CNT_W = cnt_width(LANE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LANE_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [LANE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok;
  logic                  do_pop;
  logic                  wr_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    // A pop frees the slot in the same cycle, so a full lane still takes the push.
    push_ok    = push_i && (!full_o || pop_i);
    do_pop     = pop_i && !empty_o;
    wr_en      = 1'b0;
    overflow_o = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_en      = push_ok;
      overflow_o = push_i && !push_ok;
      if (push_ok) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/hs_npu_output_collector.sv
// Receive side of the mm_unit output: per-lane buffers absorb the diagonal skew,
// whole rows are presented over valid/ready, and delivered rows are counted per job.
module hs_npu_output_collector
  import hs_npu_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANE_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            start,
  input  logic [UWORD_W-1:0]              rows_expected,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0] lane_data_i,
  input  logic [SIZE-1:0]                 lane_valid_i,
  output logic [SIZE-1:0][DATA_WIDTH-1:0] row_data_o,
  output logic                            row_valid_o,
  input  logic                            row_ready_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [SIZE-1:0]                 overflow_o
);

  // Handshake: a row moves on row_valid_o && row_ready_i; while valid is high and
  // ready is low, row_data_o and row_valid_o are held unchanged.

  logic [SIZE-1:0][DATA_WIDTH-1:0] lane_head;
  logic [SIZE-1:0]                 lane_empty;
  logic [SIZE-1:0]                 lane_full;
  logic [SIZE-1:0]                 lane_ovf;

  logic                            load;
  logic                            xfer;

  logic [SIZE-1:0][DATA_WIDTH-1:0] row_data_q, row_data_d;
  logic                            row_valid_q, row_valid_d;
  logic [SIZE-1:0]                 overflow_q, overflow_d;

  collect_state_e                  state_q, state_d;
  logic [UWORD_W-1:0]              rows_exp_q, rows_exp_d;
  logic [UWORD_W-1:0]              row_cnt_q, row_cnt_d;
  logic [UWORD_W-1:0]              row_cnt_inc;
  logic                            done_q, done_d;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    hs_npu_collector_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANE_DEPTH (LANE_DEPTH)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .push_i     (lane_valid_i[i]),
      .data_i     (lane_data_i[i]),
      .pop_i      (load),
      .head_o     (lane_head[i]),
      .empty_o    (lane_empty[i]),
      .full_o     (lane_full[i]),
      .overflow_o (lane_ovf[i])
    );
  end

  // All lanes pop together, which keeps columns aligned row after row.
  assign load = !(|lane_empty) && (!row_valid_q || row_ready_i) && !flush;
  assign xfer = row_valid_q && row_ready_i;

  always_comb begin
    row_data_d  = row_data_q;
    row_valid_d = row_valid_q;
    overflow_d  = overflow_q | lane_ovf;
    if (flush) begin
      row_data_d  = '0;
      row_valid_d = 1'b0;
      overflow_d  = '0;
    end else if (load) begin
      row_data_d  = lane_head;
      row_valid_d = 1'b1;
    end else if (xfer) begin
      row_valid_d = 1'b0;
    end
  end

  assign row_cnt_inc = row_cnt_q + UWORD_W'(1);

  always_comb begin
    state_d    = state_q;
    rows_exp_d = rows_exp_q;
    row_cnt_d  = row_cnt_q;
    done_d     = 1'b0;
    if (flush) begin
      state_d    = COLLECT_IDLE;
      rows_exp_d = '0;
      row_cnt_d  = '0;
    end else begin
      case (state_q)
        COLLECT_IDLE: begin
          if (start) begin
            rows_exp_d = rows_expected;
            row_cnt_d  = '0;
            if (rows_expected == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = COLLECT_RUN;
            end
          end
        end
        COLLECT_RUN: begin
          if (xfer) begin
            row_cnt_d = row_cnt_inc;
            if (row_cnt_inc == rows_exp_q) begin
              done_d  = 1'b1;
              state_d = COLLECT_IDLE;
            end
          end
        end
        default: state_d = COLLECT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_data_q  <= '0;
      row_valid_q <= 1'b0;
      overflow_q  <= '0;
      state_q     <= COLLECT_IDLE;
      rows_exp_q  <= '0;
      row_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      row_data_q  <= row_data_d;
      row_valid_q <= row_valid_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      rows_exp_q  <= rows_exp_d;
      row_cnt_q   <= row_cnt_d;
      done_q      <= done_d;
    end
  end

  assign row_data_o  = row_data_q;
  assign row_valid_o = row_valid_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q == COLLECT_RUN);
  assign done_o      = done_q;

endmodule

// File: tb/tb_hs_npu_output_collector.sv
// Bench for hs_npu_output_collector: per-lane word queues form expected rows,
// a negedge monitor checks every transferred row against them.
module tb_hs_npu_output_collector;

  localparam int SIZE  = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int ROW_W = SIZE * DW;

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic                      start;
  logic [31:0]               rows_expected;
  logic [SIZE-1:0][DW-1:0]   lane_data;
  logic [SIZE-1:0]           lane_valid;
  logic [SIZE-1:0][DW-1:0]   row_data_o;
  logic                      row_valid_o;
  logic                      row_ready_i;
  logic                      busy_o;
  logic                      done_o;
  logic [SIZE-1:0]           overflow_o;

  hs_npu_output_collector #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DW),
    .LANE_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .start         (start),
    .rows_expected (rows_expected),
    .lane_data_i   (lane_data),
    .lane_valid_i  (lane_valid),
    .row_data_o    (row_data_o),
    .row_valid_o   (row_valid_o),
    .row_ready_i   (row_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overflow_o    (overflow_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard
  logic [DW-1:0]    lane_m [SIZE][$];
  logic [ROW_W-1:0] exp_q[$];
  logic [SIZE-1:0]  drop_mask;

  int vectors;
  int miscompares;
  int xfer_cnt;
  int done_cnt;
  int valid_cycles;
  int run_len;
  int max_run;

  task automatic model_push();
    bit all_have;
    logic [ROW_W-1:0] row;
    for (int i = 0; i < SIZE; i++) begin
      if (lane_valid[i] && !drop_mask[i]) lane_m[i].push_back(lane_data[i]);
    end
    forever begin
      all_have = 1'b1;
      for (int i = 0; i < SIZE; i++) if (lane_m[i].size() == 0) all_have = 1'b0;
      if (!all_have) break;
      for (int i = 0; i < SIZE; i++) row[i*DW +: DW] = lane_m[i].pop_front();
      exp_q.push_back(row);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SIZE; i++) lane_m[i].delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic step();
    if (flush) model_clear();
    else model_push();
    @(posedge clk);
    #1;
    lane_valid = '0;
    flush      = 1'b0;
    start      = 1'b0;
    drop_mask  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_diag(input int nrows);
    for (int c = 0; c < nrows + SIZE - 1; c++) begin
      for (int i = 0; i < SIZE; i++) begin
        if (c - i >= 0 && c - i < nrows) begin
          lane_valid[i] = 1'b1;
          lane_data[i]  = $urandom;
        end
      end
      step();
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit empty;
    empty = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !row_valid_o) begin
        empty = 1'b1;
        break;
      end
    end
    chk(name, 64'(empty), 64'd1);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o) done_cnt++;
      if (row_valid_o) begin
        valid_cycles++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (row_valid_o && row_ready_i) begin
        logic [ROW_W-1:0] exp_row;
        xfer_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL row_xfer: got row %h with no row expected", row_data_o);
        end else begin
          exp_row = exp_q.pop_front();
          if (row_data_o !== exp_row) begin
            miscompares++;
            $display("FAIL row_xfer: got %h expected %h", row_data_o, exp_row);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int d0;
    int x0;
    int pc [SIZE];
    logic [ROW_W-1:0] held;

    vectors = 0; miscompares = 0; xfer_cnt = 0; done_cnt = 0;
    valid_cycles = 0; run_len = 0; max_run = 0;
    rst_n = 1'b0; flush = 1'b0; start = 1'b0; rows_expected = '0;
    lane_data = '0; lane_valid = '0; row_ready_i = 1'b0; drop_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_valid", 64'(row_valid_o), 64'd0);
    chk("rst_data_or", 64'(|row_data_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);

    // skewed single row: lane i pushes one cycle after lane i-1
    row_ready_i = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      lane_valid[i] = 1'b1;
      lane_data[i]  = 32'(100 + i);
      step();
    end
    @(negedge clk);
    chk("skew_t1_valid", 64'(row_valid_o), 64'd0);
    step();
    @(negedge clk);
    chk("skew_t2_valid", 64'(row_valid_o), 64'd1);
    chk("skew_lane0", 64'(row_data_o[0]), 64'd100);
    chk("skew_lane7", 64'(row_data_o[7]), 64'd107);
    step();
    @(negedge clk);
    chk("skew_one_cycle", 64'(row_valid_o), 64'd0);

    // randomized traffic with random backpressure, occupancy kept below depth
    x0 = xfer_cnt;
    for (int i = 0; i < SIZE; i++) pc[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      row_ready_i = ($urandom_range(3, 0) != 0);
      for (int i = 0; i < SIZE; i++) begin
        if ($urandom_range(1, 0) == 1 && pc[i] - (xfer_cnt - x0) < DEPTH - 2) begin
          lane_valid[i] = 1'b1;
          lane_data[i]  = $urandom;
          pc[i]++;
        end
      end
      step();
    end
    row_ready_i = 1'b1;
    wait_drain("rand_drain", 60);
    chk("rand_overflow", 64'(overflow_o), 64'd0);
    flush = 1'b1;
    step();

    // stream of 4 rows counted by a job
    rows_expected = 32'd4;
    start = 1'b1;
    step();
    @(negedge clk);
    chk("stream_busy", 64'(busy_o), 64'd1);
    d0 = done_cnt; valid_cycles = 0; max_run = 0;
    push_diag(4);
    wait_done("stream_done", 30);
    chk("stream_busy_fall", 64'(busy_o), 64'd0);
    idle(3);
    @(negedge clk);
    chk("stream_done_once", 64'(done_cnt - d0), 64'd1);
    chk("stream_valid_cycles", 64'(valid_cycles), 64'd4);
    chk("stream_contiguous", 64'(max_run), 64'd4);

    // backpressure: ready low through the pushes and 10 more cycles
    rows_expected = 32'd3;
    start = 1'b1;
    step();
    d0 = done_cnt;
    row_ready_i = 1'b0;
    push_diag(3);
    @(negedge clk);
    held = row_data_o;
    chk("bp_valid", 64'(row_valid_o), 64'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      vectors++;
      if (row_data_o !== held || !row_valid_o) begin
        miscompares++;
        $display("FAIL bp_hold: got %h/%0b expected %h/1", row_data_o, row_valid_o, held);
      end
    end
    chk("bp_overflow", 64'(overflow_o), 64'd0);
    row_ready_i = 1'b1;
    wait_done("bp_done", 20);
    idle(2);
    chk("bp_done_once", 64'(done_cnt - d0), 64'd1);
    chk("bp_busy", 64'(busy_o), 64'd0);

    // overflow: 17 words into lane 3 alone, the last is dropped
    row_ready_i = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      lane_valid = 8'h08;
      lane_data[3] = $urandom;
      if (k == DEPTH) drop_mask = 8'h08;
      step();
    end
    @(negedge clk);
    chk("ovf_flag", 64'(overflow_o), 64'h08);
    chk("ovf_no_row", 64'(row_valid_o), 64'd0);
    row_ready_i = 1'b1;
    lane_valid = 8'hF7;
    for (int i = 0; i < SIZE; i++) lane_data[i] = $urandom;
    step();
    lane_valid = 8'h08;
    lane_data[3] = $urandom;
    step();
    @(negedge clk);
    chk("ovf_push_pop_full", 64'(overflow_o), 64'h08);
    for (int k = 0; k < DEPTH; k++) begin
      lane_valid = 8'hF7;
      for (int i = 0; i < SIZE; i++) lane_data[i] = $urandom;
      step();
    end
    wait_drain("ovf_drain", 40);
    chk("ovf_sticky", 64'(overflow_o), 64'h08);
    flush = 1'b1;
    step();
    @(negedge clk);
    chk("ovf_flush_clear", 64'(overflow_o), 64'd0);

    // flush mid-job after two rows
    rows_expected = 32'd5;
    start = 1'b1;
    step();
    d0 = done_cnt;
    x0 = xfer_cnt;
    push_diag(2);
    for (int k = 0; k < 20 && xfer_cnt - x0 < 2; k++) step();
    chk("flush_two_rows", 64'(xfer_cnt - x0), 64'd2);
    lane_valid = 8'h0F;
    for (int i = 0; i < SIZE; i++) lane_data[i] = $urandom;
    step();
    row_ready_i = 1'b0;
    flush = 1'b1;
    step();
    @(negedge clk);
    chk("flush_valid", 64'(row_valid_o), 64'd0);
    chk("flush_overflow", 64'(overflow_o), 64'd0);
    chk("flush_idle", 64'(busy_o), 64'd0);
    row_ready_i = 1'b1;
    idle(5);
    chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
    rows_expected = 32'd1;
    start = 1'b1;
    step();
    @(negedge clk);
    chk("after_flush_busy", 64'(busy_o), 64'd1);
    push_diag(1);
    wait_done("after_flush_done", 20);
    chk("after_flush_idle", 64'(busy_o), 64'd0);

    // zero-row job
    step();
    rows_expected = 32'd0;
    start = 1'b1;
    step();
    @(negedge clk);
    chk("zero_done", 64'(done_o), 64'd1);
    chk("zero_busy", 64'(busy_o), 64'd0);
    step();
    @(negedge clk);
    chk("zero_done_pulse", 64'(done_o), 64'd0);
    chk("zero_busy_after", 64'(busy_o), 64'd0);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
